// File: rtl/alu_seq16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the nibble-serial ALU
//                sequencer: FSM state encoding, operation codes and the
//                ALUOP selector values of the 4-bit alu slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation codes presented on op
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_INC   = 3'b001;
    localparam logic [2:0] OP_PASS  = 3'b010;
    localparam logic [2:0] OP_RSVD  = 3'b011;
    // op[2] set selects the logic group; op[1:0] then passes straight to ALUOP
    localparam logic       OP_LOGIC = 1'b1;

    // ALUOP selector values for arithmetic mode (l = 0)
    localparam logic [1:0] ALUOP_SUM  = 2'b10;
    localparam logic [1:0] ALUOP_INC  = 2'b01;
    localparam logic [1:0] ALUOP_PASS = 2'b00;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq16_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 4-bit ALU slice. Arithmetic mode (l=0):
//                  00 A + c_in, 01 A + 1 + c_in, 10 A + B + c_in,
//                  11 A + ~B + c_in.
//                Logic mode (l=1): 00 AND, 01 OR, 10 XOR, 11 NOT A;
//                c_out is 0 in logic mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [1:0] ALUOP,
    input  logic       l,
    input  logic       c_in,
    output logic [3:0] R,
    output logic       c_out
);

    logic [4:0] w_sum;

    // Single-nibble function select; arithmetic results carry into bit 4
    always_comb begin
        w_sum = 5'd0;
        R     = 4'd0;
        c_out = 1'b0;
        if (l) begin
            case (ALUOP)
                2'b00:   R = A & B;
                2'b01:   R = A | B;
                2'b10:   R = A ^ B;
                default: R = ~A;
            endcase
        end else begin
            case (ALUOP)
                2'b00:   w_sum = {1'b0, A} + {4'd0, c_in};
                2'b01:   w_sum = {1'b0, A} + 5'd1 + {4'd0, c_in};
                2'b10:   w_sum = {1'b0, A} + {1'b0, B} + {4'd0, c_in};
                default: w_sum = {1'b0, A} + {1'b0, ~B} + {4'd0, c_in};
            endcase
            R     = w_sum[3:0];
            c_out = w_sum[4];
        end
    end

endmodule : alu
`default_nettype wire

// File: rtl/alu_seq16.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq16
//  Description : Runs W-bit (W = 4*NIB) operations on one shared 4-bit alu
//                slice, one nibble per clock, LS nibble first, with carry
//                chained between nibbles. Operands are latched on start,
//                done pulses for one cycle when result and flags are valid.
//  Options     : ALU_SEQ16_SAT_EN - ADD and INC saturate to all ones on a
//                final carry (cout stays 1, flags follow the saturated value)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq16
    import alu_seq_pkg::*;
#(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         sign
);

    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2:0]       r_op;
    logic             r_cin;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_sign;

    logic [IDX_W+1:0] w_base;
    logic             w_first;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [1:0]       w_aluop;
    logic             w_l;
    logic             w_c_in;
    logic [3:0]       w_r;
    logic             w_c_out;
    logic [W-1:0]     w_final_result;
    logic             w_final_cout;
    logic [W-1:0]     w_flag_result;

    assign w_base  = {r_idx, 2'b00};
    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == C_LAST_IDX);
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];

    // ALU control for the current nibble: mode, function and carry-in
    always_comb begin
        w_l     = 1'b0;
        w_aluop = ALUOP_PASS;
        w_c_in  = w_first ? 1'b0 : r_carry;
        if (r_op[2] == OP_LOGIC) begin
            w_l     = 1'b1;
            w_aluop = r_op[1:0];
            w_c_in  = 1'b0;
        end else begin
            case (r_op)
                OP_ADD: begin
                    w_aluop = ALUOP_SUM;
                    w_c_in  = w_first ? r_cin : r_carry;
                end
                OP_INC: begin
                    w_aluop = w_first ? ALUOP_INC : ALUOP_PASS;
                end
                OP_PASS, OP_RSVD: begin
                    w_aluop = ALUOP_PASS;
                end
                default: begin
                    w_aluop = ALUOP_PASS;
                end
            endcase
        end
    end

    alu u_alu (
        .A     (w_a_nib),
        .B     (w_b_nib),
        .ALUOP (w_aluop),
        .l     (w_l),
        .c_in  (w_c_in),
        .R     (w_r),
        .c_out (w_c_out)
    );

    // Result with the current nibble merged in, and the carry seen so far
    always_comb begin
        w_final_result = r_result;
        w_final_result[w_base +: 4] = w_r;
    end

    assign w_final_cout = (r_op[2] == OP_LOGIC) ? 1'b0 : w_c_out;

`ifdef ALU_SEQ16_SAT_EN
    logic w_sat_op;
    assign w_sat_op      = (r_op == OP_ADD) || (r_op == OP_INC);
    assign w_flag_result = (w_sat_op && w_final_cout) ? {W{1'b1}} : w_final_result;
`else
    assign w_flag_result = w_final_result;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, nibble stepping, result assembly and flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b1;
            r_sign   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_op     <= op;
                        r_cin    <= cin;
                        r_idx    <= '0;
                        r_carry  <= 1'b0;
                        r_result <= '0;
                    end
                end
                RUN: begin
                    r_carry <= w_c_out;
                    if (w_last) begin
                        r_result <= w_flag_result;
                        r_cout   <= w_final_cout;
                        r_zero   <= (w_flag_result == '0);
                        r_sign   <= w_flag_result[W-1];
                    end else begin
                        r_result <= w_final_result;
                        r_idx    <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign sign   = r_sign;

endmodule : alu_seq16
`default_nettype wire

// File: tb/tb_alu_seq16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq16
//  Description : Self-checking bench for alu_seq16 (NIB = 4). A word-level
//                model predicts busy/done timing and the finished result and
//                flags; hand-computed literals pin selected operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq16;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         sign;

    alu_seq16 #(.NIB(NIB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .sign   (sign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         sign;
    } exp_t;

    // Word-level reference: plain arithmetic on the full operands
    function automatic exp_t model_op(input logic [2:0] o, input logic [W-1:0] x,
                                      input logic [W-1:0] y, input logic ci);
        logic [W:0] s;
        exp_t       e;
        s = '0;
        if (o[2]) begin
            case (o[1:0])
                2'b00:   s = {1'b0, x & y};
                2'b01:   s = {1'b0, x | y};
                2'b10:   s = {1'b0, x ^ y};
                default: s = {1'b0, ~x};
            endcase
        end else if (o == 3'b000) begin
            s = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        end else if (o == 3'b001) begin
            s = {1'b0, x} + (W+1)'(1);
        end else begin
            s = {1'b0, x};
        end
`ifdef ALU_SEQ16_SAT_EN
        if (!o[2] && !o[1] && s[W]) s[W-1:0] = '1;
`endif
        e.res  = s[W-1:0];
        e.cout = s[W];
        e.zero = (s[W-1:0] == '0);
        e.sign = s[W-1];
        return e;
    endfunction

    // Literal expectations, consumed in order at each predicted done
    exp_t lits [0:31];
    int   lit_wr = 0;
    int   lit_rd = 0;
    exp_t lit_cur;
    logic lit_on = 1'b0;

    // Model state
    int   m_left  = 0;
    logic m_done  = 1'b0;
    logic m_valid = 1'b1;
    exp_t m_exp   = '{res: '0, cout: 1'b0, zero: 1'b1, sign: 1'b0};
    exp_t p_exp   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_valid <= 1'b1;
            m_exp   <= '{res: '0, cout: 1'b0, zero: 1'b1, sign: 1'b0};
            lit_on  <= 1'b0;
        end else begin
            lit_on <= 1'b0;
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done  <= 1'b1;
                    m_valid <= 1'b1;
                    m_exp   <= p_exp;
                    if (lit_rd < lit_wr) begin
                        lit_cur <= lits[lit_rd];
                        lit_rd  <= lit_rd + 1;
                        lit_on  <= 1'b1;
                    end
                end
            end else if (start) begin
                m_left  <= NIB;
                m_valid <= 1'b0;
                p_exp   <= model_op(op, a, b, cin);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model and literals away from the active edge
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left > 0));
        check("done", 32'(done), 32'(m_done));
        if (m_valid) begin
            check("result", 32'(result), 32'(m_exp.res));
            check("cout",   32'(cout),   32'(m_exp.cout));
            check("zero",   32'(zero),   32'(m_exp.zero));
            check("sign",   32'(sign),   32'(m_exp.sign));
        end
        if (lit_on) begin
            check("lit_result", 32'(result), 32'(lit_cur.res));
            check("lit_cout",   32'(cout),   32'(lit_cur.cout));
            check("lit_zero",   32'(zero),   32'(lit_cur.zero));
            check("lit_sign",   32'(sign),   32'(lit_cur.sign));
        end
    end

    task automatic push_lit(input logic [W-1:0] r, input logic c, input logic z, input logic s);
        lits[lit_wr] = '{res: r, cout: c, zero: z, sign: s};
        lit_wr++;
    endtask

    // One operation at full throughput; operands scrambled after acceptance
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic [W-1:0] r, input logic c,
                         input logic z, input logic s);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        cin   = ci;
        push_lit(r, c, z, s);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        repeat (NIB + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run: no done, outputs back to reset values
        start = 1'b1;
        op    = 3'b000;
        a     = 16'h1234;
        b     = 16'h1111;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        do_op(3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ16_SAT_EN
        do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        do_op(3'b000, 16'h8000, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        do_op(3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
`else
        do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(3'b000, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
`endif
        do_op(3'b000, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);
        do_op(3'b001, 16'h0FFF, 16'h5555, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        do_op(3'b001, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        do_op(3'b010, 16'hBEEF, 16'h1234, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        do_op(3'b011, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op(3'b100, 16'hA5C3, 16'h0FF0, 1'b1, 16'h05C0, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 16'hA5C3, 16'h0FF0, 1'b1, 16'hAFF3, 1'b0, 1'b0, 1'b1);
        do_op(3'b110, 16'hA5C3, 16'h0FF0, 1'b1, 16'hAA33, 1'b0, 1'b0, 1'b1);
        do_op(3'b111, 16'hA5C3, 16'h0FF0, 1'b1, 16'h5A3C, 1'b0, 1'b0, 1'b0);

        // start held high: accepted at T and T+NIB+2 only
        start = 1'b1;
        op    = 3'b010;
        a     = 16'h0005;
        b     = 16'h0000;
        cin   = 1'b0;
        push_lit(16'h0005, 1'b0, 1'b0, 1'b0);
        push_lit(16'h0005, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_seq16
`default_nettype wire

// File: doc/alu_seq16.md
# alu_seq16

Multi-cycle sequencer that runs W-bit operations (W = 4·NIB) on one shared 4-bit `alu` slice, one nibble per clock, least-significant nibble first. Arithmetic carries chain between nibbles. The block sits between the control unit and the ALU. It latches operands on a `start` pulse, steps the ALU control lines (`ALUOP`, `l`, `c_in`), assembles the result, and reports completion with a `done` pulse.

## Interface
- NIB, 4, number of nibbles; W = 4·NIB; legal range 2..8
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code, latched with start
- a  in  W  operand A, latched with start
- b  in  W  operand B, latched with start
- cin  in  1  carry into nibble 0 for ADD, latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result and flags are valid
- result  out  W  assembled result, held until the next accepted start
- cout  out  1  carry out of the top nibble; 0 for logic ops
- zero  out  1  result == 0 over the full W
- sign  out  1  result[W-1]

## Operation
- FSM states:
  - IDLE: start=1 latches op/a/b/cin, clears idx and result, goes to RUN.
  - RUN: one nibble per cycle; when idx == NIB-1, goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Nibble idx drives the ALU with A = a_q[4·idx+3:4·idx] and B = b_q[same]. At the clock edge, R is written into result[same] and c_out into the carry register.
- Op encoding:
  - 000 ADD: l=0, ALUOP=10; c_in = cin_q on nibble 0, carry register after.
  - 001 INC: l=0; nibble 0 uses ALUOP=01 with c_in=0; later nibbles use ALUOP=00 with c_in = carry register.
  - 010 PASS: l=0, ALUOP=00; c_in=0 on nibble 0, chained after (yields a_q).
  - 011 reserved: behaves as PASS.
  - 1xx LOGIC: l=1, ALUOP=op[1:0], c_in=0 on every nibble; no chaining; cout forced 0.
- Flags: zero, sign and cout are registered at entry to DONE and held with result.
- start while busy or in DONE: ignored, not queued.
- Operand inputs may change freely after acceptance; only the latched copies are used.

## Timing
- Reset (async assert, sync deassert in the system): state=IDLE, busy=0, done=0, result=0, cout=0, zero=1, sign=0. Internal idx, carry and operand registers are 0.
- Latency: start sampled at edge T.
  - busy=1 over cycles T+1..T+NIB.
  - done=1 in cycle T+NIB+1.
  - Next start is accepted no earlier than edge T+NIB+2.
- Throughput: one op per NIB+2 cycles.
- Reset asserted mid-RUN aborts at once: partial result is discarded and no done is issued.
- result[4·i+3:4·i] updates at the end of nibble i. Consumers read result only when done=1 or later.

## Configuration
- ALU_SEQ16_SAT_EN defined: ADD and INC saturate. If the final carry is 1, DONE presents result = all ones and cout=1. zero and sign are computed on the saturated value.
- Undefined: result wraps modulo 2^W and cout reports the carry.
- Logic and PASS ops are unaffected either way.

## Structure
- Shared package alu_seq_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - op code constants (OP_ADD, OP_INC, OP_PASS, OP_LOGIC prefix)
  - ALUOP constants (ALUOP_SUM=2'b10, ALUOP_INC=2'b01, ALUOP_PASS=2'b00)
- One sub-module: the existing 4-bit `alu`, instantiated once. It is driven from the nibble mux; its R and c_out are captured.
- Nibble select, carry register, FSM and flag logic stay in alu_seq16.

## Test plan
- Reset mid-RUN: start ADD with a=16'h1234, b=16'h1111, then pull rst_n low at T+2 → outputs return to reset values immediately; no done pulse.
- ADD with chain: a=16'h00FF, b=16'h0001, cin=0 → done at T+5; result=16'h0100, cout=0, zero=0, sign=0.
- ADD overflow: a=16'hFFFF, b=16'h0001, cin=0.
  - Without the macro: result=16'h0000, cout=1, zero=1.
  - With ALU_SEQ16_SAT_EN: result=16'hFFFF, cout=1, zero=0, sign=1.
- INC across nibbles: a=16'h0FFF → result=16'h1000, cout=0. Then a=16'h7FFF → result=16'h8000, sign=1.
- start held high through a whole op plus 3 cycles, a=16'h0005, op=PASS → exactly one op per NIB+2 cycles.
  - Each done is followed by re-acceptance.
  - No acceptance occurs during busy or done.
- LOGIC op=1xx, all four codes, a=16'hA5C3, b=16'h0FF0.
  - Each nibble equals the single-nibble `alu` reference model output for l=1.
  - cout=0.
  - zero and sign match the assembled result.
